// File: rtl/pwm_generator_multi.sv
// Multi-channel PWM generator: shared period counter, per-channel duty, shadow->active updates at period boundaries.
// Optional center-aligned counting is enabled by defining PWM_CENTER_ALIGN_EN.
module pwm_generator_multi #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned INITIAL_PERIOD = 8,
    parameter int unsigned INITIAL_DUTY   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          pwm_period,
    input  logic [CHANNELS*WIDTH-1:0] pwm_duty_cycle,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                      center_align,
`endif
    input  logic                      update_parameters,
    output logic                      update_pending,
    output logic                      period_end,
    output logic [CHANNELS-1:0]       pwm
);
    localparam int unsigned WX = WIDTH + 1;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    logic [WIDTH-1:0]                cnt_q, cnt_d;
    dir_e                            dir_q, dir_d;
    logic [WIDTH-1:0]                act_period_q, act_period_d;
    logic [WIDTH-1:0]                sh_period_q, sh_period_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  act_duty_q, act_duty_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  sh_duty_q, sh_duty_d;
    logic                            act_center_q, act_center_d;
    logic                            sh_center_q, sh_center_d;
    logic                            pending_q, pending_d;
    logic                            req_center_c;
    logic [WIDTH-1:0]                req_period_c;
    logic [WIDTH-1:0]                last_c;
    logic                            apply_c;

`ifdef PWM_CENTER_ALIGN_EN
    assign req_center_c = center_align;
`else
    assign req_center_c = 1'b0;
`endif

    // Outputs decode registered state only.
    always_comb begin
        last_c = act_period_q - WIDTH'(1);
        if (act_center_q) begin
            period_end = (dir_q == DIR_DOWN) && (cnt_q == '0);
        end else begin
            period_end = (cnt_q == last_c);
        end
        update_pending = pending_q;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (act_center_q) begin
                // cnt >= P - D, evaluated one bit wider so D >= P needs no special case
                pwm[i] = (WX'(cnt_q) + WX'(act_duty_q[i])) >= WX'(act_period_q);
            end else begin
                pwm[i] = (cnt_q < act_duty_q[i]);
            end
        end
    end

    // Shadow capture, boundary apply and counter sequencing.
    always_comb begin
        req_period_c = (pwm_period == '0) ? WIDTH'(1) : pwm_period;
        sh_period_d  = update_parameters ? req_period_c   : sh_period_q;
        sh_duty_d    = update_parameters ? pwm_duty_cycle : sh_duty_q;
        sh_center_d  = update_parameters ? req_center_c   : sh_center_q;
        pending_d    = pending_q | update_parameters;
        act_period_d = act_period_q;
        act_duty_d   = act_duty_q;
        act_center_d = act_center_q;
        cnt_d        = cnt_q + WIDTH'(1);
        dir_d        = dir_q;
        apply_c      = period_end && (pending_q || update_parameters);

        if (!act_center_q) begin
            if (cnt_q == last_c) begin
                cnt_d = '0;
            end
        end else if (dir_q == DIR_UP) begin
            if (cnt_q == last_c) begin
                cnt_d = cnt_q;
                dir_d = DIR_DOWN;
            end
        end else begin
            if (cnt_q == '0) begin
                cnt_d = '0;
                dir_d = DIR_UP;
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end

        // A same-cycle update is already folded into the shadow next-values.
        if (apply_c) begin
            act_period_d = sh_period_d;
            act_duty_d   = sh_duty_d;
            act_center_d = sh_center_d;
            pending_d    = 1'b0;
            cnt_d        = '0;
            dir_d        = DIR_UP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            act_period_q <= WIDTH'(INITIAL_PERIOD);
            sh_period_q  <= WIDTH'(INITIAL_PERIOD);
            act_duty_q   <= {CHANNELS{WIDTH'(INITIAL_DUTY)}};
            sh_duty_q    <= {CHANNELS{WIDTH'(INITIAL_DUTY)}};
            act_center_q <= 1'b0;
            sh_center_q  <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            act_period_q <= act_period_d;
            sh_period_q  <= sh_period_d;
            act_duty_q   <= act_duty_d;
            sh_duty_q    <= sh_duty_d;
            act_center_q <= act_center_d;
            sh_center_q  <= sh_center_d;
            pending_q    <= pending_d;
        end
    end

endmodule
